// File: rtl/carrier_pkg.sv
// Shared widths, latency and quadrant helpers for the carrier NCO and its quarter-wave ROM.
// The optional cosine output is enabled with the CARRIER_NCO_COS_EN macro.
package carrier_pkg;

  localparam int PHASE_W_D = 24;
  localparam int ADDR_W_D  = 8;
  localparam int AMP_W_D   = 8;
  localparam int NCO_LAT   = 4;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  // Quadrants 1 and 3 walk the quarter table backwards; 2 and 3 are negated.
  function automatic logic quad_mirror(input quadrant_t q);
    return (q == Q1) || (q == Q3);
  endfunction

  function automatic logic quad_negate(input quadrant_t q);
    return (q == Q2) || (q == Q3);
  endfunction

  // round((2^(amp_w-1)-1) * sin(pi*(2k+1)/2^addr_w)) using a Q30 Taylor series,
  // evaluated only at elaboration to fill the ROM.
  function automatic int qsin_entry(input int k, input int addr_w, input int amp_w);
    longint pi_fx;
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    pi_fx = 64'sd3373259426;
    x     = (pi_fx * longint'(2 * k + 1)) / (longint'(1) <<< addr_w);
    x2    = (x * x) / (longint'(1) <<< 30);
    term  = x;
    sum   = x;
    for (int n = 1; n <= 10; n++) begin
      term = -((term * x2) / (longint'(1) <<< 30)) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) <<< (amp_w - 1)) - 1;
    return int'((sum * amp + (longint'(1) <<< 29)) / (longint'(1) <<< 30));
  endfunction

endpackage

// File: rtl/carrier_qrom.sv
// Quarter-wave sine ROM with registered read; second read port under CARRIER_NCO_COS_EN.
// Contents equal the carrier_qsin.hex image and are generated at elaboration.
module carrier_qrom
  import carrier_pkg::*;
#(
  parameter int    DEPTH_W   = ADDR_W_D - 2,
  parameter int    AMP_W     = AMP_W_D,
  parameter string INIT_FILE = "carrier_qsin.hex"
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DEPTH_W-1:0] addr_a,
  output logic [AMP_W-1:0]   data_a
`ifdef CARRIER_NCO_COS_EN
  ,
  input  logic [DEPTH_W-1:0] addr_b,
  output logic [AMP_W-1:0]   data_b
`endif
);

  localparam int    DEPTH            = 1 << DEPTH_W;
  localparam string unused_init_file = INIT_FILE;

  logic [AMP_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    localparam logic [AMP_W-1:0] ENTRY = AMP_W'(qsin_entry(k, DEPTH_W + 2, AMP_W));
    assign rom[k] = ENTRY;
  end

  always_ff @(posedge clk) begin
    if (reset) data_a <= '0;
    else       data_a <= rom[addr_a];
  end

`ifdef CARRIER_NCO_COS_EN
  always_ff @(posedge clk) begin
    if (reset) data_b <= '0;
    else       data_b <= rom[addr_b];
  end
`endif

endmodule

// File: rtl/carrier_nco.sv
// Numerically controlled carrier: phase accumulator, quarter-wave ROM lookup, signed output.
// Define CARRIER_NCO_COS_EN to add the quadrature output dout_cos.
module carrier_nco
  import carrier_pkg::*;
#(
  parameter int    PHASE_W   = PHASE_W_D,
  parameter int    ADDR_W    = ADDR_W_D,
  parameter int    AMP_W     = AMP_W_D,
  parameter string INIT_FILE = "carrier_qsin.hex"
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               fcw_wr,
  input  logic [PHASE_W-1:0] fcw_in,
  input  logic [PHASE_W-1:0] phase_ofs,
  input  logic               phase_clr,
  output logic [AMP_W-1:0]   dout,
  output logic               dout_valid
`ifdef CARRIER_NCO_COS_EN
  ,
  output logic [AMP_W-1:0]   dout_cos
`endif
);

  // Valid semantics: there is no backpressure. dout_valid is ce delayed by
  // NCO_LAT cycles and marks dout as the sample of the acc value seen with ce=1.
  localparam int FINE_W = ADDR_W - 2;

  logic [PHASE_W-1:0] fcw_q;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ph1;
  logic               valid1;
  logic [FINE_W-1:0]  idx2;
  logic               neg2;
  logic               valid2;
  logic [AMP_W-1:0]   rom3;
  logic               neg3;
  logic               valid3;

  logic [ADDR_W-1:0]  addr1;
  quadrant_t          quad;
  logic [FINE_W-1:0]  fine;

  assign addr1 = ph1[PHASE_W-1 -: ADDR_W];
  assign quad  = quadrant_t'(addr1[ADDR_W-1 -: 2]);
  assign fine  = addr1[FINE_W-1:0];

  if (PHASE_W > ADDR_W) begin : g_lsb
    logic unused_ph1_lsb;
    assign unused_ph1_lsb = ^ph1[PHASE_W-ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcw_q <= '0;
    end else if (fcw_wr) begin
      fcw_q <= fcw_in;
    end
  end

  // Clear takes priority over the increment.
  always_ff @(posedge clk) begin
    if (reset || phase_clr) begin
      acc <= '0;
    end else if (ce) begin
      acc <= acc + fcw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph1        <= '0;
      valid1     <= 1'b0;
      idx2       <= '0;
      neg2       <= 1'b0;
      valid2     <= 1'b0;
      neg3       <= 1'b0;
      valid3     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      ph1        <= acc + phase_ofs;
      valid1     <= ce;
      idx2       <= quad_mirror(quad) ? ~fine : fine;
      neg2       <= quad_negate(quad);
      valid2     <= valid1;
      neg3       <= neg2;
      valid3     <= valid2;
      dout       <= neg3 ? -rom3 : rom3;
      dout_valid <= valid3;
    end
  end

`ifdef CARRIER_NCO_COS_EN
  quadrant_t         quad_c;
  logic [FINE_W-1:0] idx2_c;
  logic              neg2_c;
  logic [AMP_W-1:0]  rom3_c;
  logic              neg3_c;

  // Cosine is the same lookup one quadrant ahead.
  assign quad_c = quadrant_t'(2'(quad + 2'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idx2_c   <= '0;
      neg2_c   <= 1'b0;
      neg3_c   <= 1'b0;
      dout_cos <= '0;
    end else begin
      idx2_c   <= quad_mirror(quad_c) ? ~fine : fine;
      neg2_c   <= quad_negate(quad_c);
      neg3_c   <= neg2_c;
      dout_cos <= neg3_c ? -rom3_c : rom3_c;
    end
  end
`endif

  carrier_qrom #(
    .DEPTH_W  (FINE_W),
    .AMP_W    (AMP_W),
    .INIT_FILE(INIT_FILE)
  ) u_qrom (
    .clk   (clk),
    .reset (reset),
    .addr_a(idx2),
    .data_a(rom3)
`ifdef CARRIER_NCO_COS_EN
    ,
    .addr_b(idx2_c),
    .data_b(rom3_c)
`endif
  );

endmodule

// File: tb/tb_carrier_nco.sv
// Directed, table-driven bench for carrier_nco with hand-computed sine samples
// (default widths: 24-bit phase, 256-entry full wave, 8-bit amplitude).
module tb_carrier_nco;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        fcw_wr;
  logic [23:0] fcw_in;
  logic [23:0] phase_ofs;
  logic        phase_clr;
  logic [7:0]  dout;
  logic        dout_valid;
`ifdef CARRIER_NCO_COS_EN
  logic [7:0]  dout_cos;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] samp [0:259];

  typedef struct {
    int         n;
    logic [7:0] sin_exp;
  } stream_vec_t;

  typedef struct {
    logic [23:0] ofs;
    logic [7:0]  sin_exp;
    logic [7:0]  cos_exp;
  } ofs_vec_t;

  typedef struct {
    logic [23:0] fcw;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [7:0]  e3;
  } fcw_vec_t;

  typedef struct {
    logic       ce;
    logic [7:0] sin_exp;
  } ce_vec_t;

  stream_vec_t svec [12];
  ofs_vec_t    ovec [6];
  fcw_vec_t    fvec [2];
  ce_vec_t     cvec [8];

  carrier_nco dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .fcw_wr    (fcw_wr),
    .fcw_in    (fcw_in),
    .phase_ofs (phase_ofs),
    .phase_clr (phase_clr),
    .dout      (dout),
    .dout_valid(dout_valid)
`ifdef CARRIER_NCO_COS_EN
    ,
    .dout_cos  (dout_cos)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // driver: load fcw, clear acc with ce low, then raise ce; returns in cycle C0 (acc=0)
  task automatic start_stream(input logic [23:0] fcw, input logic [23:0] ofs);
    phase_clr = 1'b1;
    fcw_wr    = 1'b1;
    fcw_in    = fcw;
    phase_ofs = ofs;
    ce        = 1'b0;
    tick();
    phase_clr = 1'b0;
    fcw_wr    = 1'b0;
    ce        = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int bad_valid;

    svec[0]  = '{0,   8'h02};
    svec[1]  = '{1,   8'h05};
    svec[2]  = '{2,   8'h08};
    svec[3]  = '{3,   8'h0B};
    svec[4]  = '{63,  8'h7F};
    svec[5]  = '{64,  8'h7F};
    svec[6]  = '{128, 8'hFE};
    svec[7]  = '{129, 8'hFB};
    svec[8]  = '{192, 8'h81};
    svec[9]  = '{255, 8'hFE};
    svec[10] = '{256, 8'h02};
    svec[11] = '{257, 8'h05};

    ovec[0] = '{24'h000000, 8'h02, 8'h7F};
    ovec[1] = '{24'h400000, 8'h7F, 8'hFE};
    ovec[2] = '{24'h800000, 8'hFE, 8'h81};
    ovec[3] = '{24'hC00000, 8'h81, 8'h02};
    ovec[4] = '{24'h030000, 8'h0B, 8'h7F};
    ovec[5] = '{24'h810000, 8'hFB, 8'h81};

    fvec[0] = '{24'hFFFFFF, 8'h02, 8'hFE, 8'hFE, 8'hFE};
    fvec[1] = '{24'hFF0000, 8'h02, 8'hFE, 8'hFB, 8'hF8};

    cvec[0] = '{1'b1, 8'h02};
    cvec[1] = '{1'b0, 8'h00};
    cvec[2] = '{1'b1, 8'h05};
    cvec[3] = '{1'b0, 8'h00};
    cvec[4] = '{1'b1, 8'h08};
    cvec[5] = '{1'b1, 8'h0B};
    cvec[6] = '{1'b0, 8'h00};
    cvec[7] = '{1'b0, 8'h00};

    reset     = 1'b1;
    ce        = 1'b0;
    fcw_wr    = 1'b0;
    fcw_in    = '0;
    phase_ofs = '0;
    phase_clr = 1'b0;
    ticks(2);
    check("reset_dout", dout, 8'h00);
    check("reset_valid", dout_valid, 1'b0);
    reset = 1'b0;

    // full-period stream at one table step per sample
    start_stream(24'h010000, 24'h000000);
    ticks(3);
    check("latency_valid_low", dout_valid, 1'b0);
    tick();
    check("first_valid", dout_valid, 1'b1);
    check("first_dout", dout, 8'h02);
`ifdef CARRIER_NCO_COS_EN
    check("first_cos", dout_cos, 8'h7F);
`endif
    bad_valid = 0;
    samp[0] = dout;
    for (int n = 1; n < 260; n++) begin
      tick();
      samp[n] = dout;
      if (dout_valid !== 1'b1) bad_valid++;
    end
    check("stream_valid_gaps", bad_valid, 0);
    for (int v = 0; v < 12; v++) begin
      check($sformatf("stream_n%0d", svec[v].n), samp[svec[v].n], svec[v].sin_exp);
    end

    // static phase offsets with a zero tuning word
    for (int v = 0; v < 6; v++) begin
      start_stream(24'h000000, ovec[v].ofs);
      ticks(4);
      check($sformatf("ofs_%06h", ovec[v].ofs), dout, ovec[v].sin_exp);
`ifdef CARRIER_NCO_COS_EN
      check($sformatf("ofs_cos_%06h", ovec[v].ofs), dout_cos, ovec[v].cos_exp);
`endif
      ticks(3);
      check($sformatf("ofs_hold_%06h", ovec[v].ofs), dout, ovec[v].sin_exp);
    end
    phase_ofs = '0;

    // near-full-scale tuning words wrap the accumulator every cycle
    for (int v = 0; v < 2; v++) begin
      start_stream(fvec[v].fcw, 24'h000000);
      ticks(4);
      exp_q.push_back(fvec[v].e0);
      exp_q.push_back(fvec[v].e1);
      exp_q.push_back(fvec[v].e2);
      exp_q.push_back(fvec[v].e3);
      for (int s = 0; s < 4; s++) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check($sformatf("wrap_%06h_s%0d_valid", fvec[v].fcw, s), dout_valid, 1'b1);
        check($sformatf("wrap_%06h_s%0d", fvec[v].fcw, s), dout, e);
        tick();
      end
    end

    // ce toggling: valid follows ce four cycles later, acc only steps on ce
    start_stream(24'h010000, 24'h000000);
    for (int k = 0; k < 12; k++) begin
      ce = (k < 8) ? cvec[k].ce : 1'b0;
      if (k >= 4) begin
        check($sformatf("ce_valid_k%0d", k - 4), dout_valid, cvec[k-4].ce);
        if (cvec[k-4].ce) check($sformatf("ce_dout_k%0d", k - 4), dout, cvec[k-4].sin_exp);
      end
      tick();
    end

    // phase_clr with ce: four samples drain, then the sequence restarts at addr 0
    start_stream(24'h010000, 24'h000000);
    ticks(10);
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    exp_q.push_back(8'h17);
    exp_q.push_back(8'h1A);
    exp_q.push_back(8'h1D);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h05);
    for (int s = 0; s < 6; s++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("clr_s%0d_valid", s), dout_valid, 1'b1);
      check($sformatf("clr_s%0d", s), dout, e);
      tick();
    end

    // one-cycle reset mid-stream flushes the pipeline and zeroes fcw_q
    start_stream(24'h010000, 24'h000000);
    ticks(6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_dout", dout, 8'h00);
    check("rst_mid_valid", dout_valid, 1'b0);
    bad_valid = 0;
    for (int k = 1; k < 4; k++) begin
      tick();
      if (dout_valid !== 1'b0) bad_valid++;
    end
    check("rst_flush_valid", bad_valid, 0);
    for (int k = 4; k < 8; k++) begin
      tick();
      check($sformatf("rst_const_r%0d_valid", k), dout_valid, 1'b1);
      check($sformatf("rst_const_r%0d", k), dout, 8'h02);
    end
    fcw_in = 24'h010000;
    fcw_wr = 1'b1;
    tick();
    fcw_wr = 1'b0;
    ticks(4);
    check("fcw_wr_first", dout, 8'h02);
    tick();
    check("fcw_wr_step", dout, 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
